// File: rtl/accel_axil_regs_if.sv
// AXI4-Lite bus bundle for the accelerator S00_AXI control port.
// The master modport drives requests; the slave modport drives ready/response signals.
interface accel_axil_regs_if #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/accel_axil_regs.sv
// AXI4-Lite slave register file exporting C_NUM_REGS 32-bit registers and write pulses.
// Define ACCEL_AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR instead of aliasing.
module accel_axil_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned C_NUM_REGS         = 4
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESET,
  accel_axil_regs_if.slave         s_axi,
  output logic [32*C_NUM_REGS-1:0] reg_out,
  output logic [C_NUM_REGS-1:0]    reg_wr
);

  localparam int unsigned IdxW = $clog2(C_NUM_REGS);

  logic [31:0]                   r_regs [C_NUM_REGS];
  logic                          r_aw_held;
  logic [C_S_AXI_ADDR_WIDTH-1:0] r_aw_addr;
  logic                          r_w_held;
  logic [31:0]                   r_wdata;
  logic [3:0]                    r_wstrb;
  logic                          r_bvalid;
  logic [1:0]                    r_bresp;
  logic                          r_rvalid;
  logic [31:0]                   r_rdata;
  logic [1:0]                    r_rresp;
  logic [C_NUM_REGS-1:0]         r_wr_stage;
  logic [C_NUM_REGS-1:0]         r_reg_wr;

  logic            w_awready;
  logic            w_wready;
  logic            w_arready;
  logic            w_aw_hs;
  logic            w_w_hs;
  logic            w_ar_hs;
  logic            w_commit;
  logic [IdxW-1:0] w_aw_idx;
  logic [IdxW-1:0] w_ar_idx;
  logic            w_aw_oor;
  logic            w_ar_oor;
  logic            w_unused;

  assign w_awready = !r_aw_held && !r_bvalid && !S_AXI_ARESET;
  assign w_wready  = !r_w_held && !r_bvalid && !S_AXI_ARESET;
  assign w_arready = !r_rvalid && !S_AXI_ARESET;

  assign w_aw_hs  = s_axi.S_AXI_AWVALID && w_awready;
  assign w_w_hs   = s_axi.S_AXI_WVALID && w_wready;
  assign w_ar_hs  = s_axi.S_AXI_ARVALID && w_arready;
  assign w_commit = r_aw_held && r_w_held;

  assign w_aw_idx = r_aw_addr[IdxW+1:2];
  assign w_ar_idx = s_axi.S_AXI_ARADDR[IdxW+1:2];

`ifdef ACCEL_AXIL_SLVERR_EN
  assign w_aw_oor = (r_aw_addr >> (IdxW + 2)) != '0;
  assign w_ar_oor = (s_axi.S_AXI_ARADDR >> (IdxW + 2)) != '0;
`else
  // Upper address bits are dropped, so the register window aliases.
  assign w_aw_oor = 1'b0;
  assign w_ar_oor = 1'b0;
`endif

  assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, r_aw_addr, s_axi.S_AXI_ARADDR};

  // Write path: AW and W are latched independently; commit once both are held.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < int'(C_NUM_REGS); i++) r_regs[i] <= '0;
      r_aw_held  <= 1'b0;
      r_aw_addr  <= '0;
      r_w_held   <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= 2'b00;
      r_wr_stage <= '0;
      r_reg_wr   <= '0;
    end else begin
      r_wr_stage <= '0;
      r_reg_wr   <= r_wr_stage;
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= s_axi.S_AXI_AWADDR;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axi.S_AXI_WDATA[31:0];
        r_wstrb  <= s_axi.S_AXI_WSTRB[3:0];
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_aw_oor ? 2'b10 : 2'b00;
        if (!w_aw_oor) begin
          r_wr_stage[w_aw_idx] <= 1'b1;
          for (int k = 0; k < 4; k++) begin
            if (r_wstrb[k]) r_regs[w_aw_idx][8*k +: 8] <= r_wdata[8*k +: 8];
          end
        end
      end else if (r_bvalid && s_axi.S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Read path samples the registers before any same-edge commit lands.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_ar_oor ? 32'h0 : r_regs[w_ar_idx];
      r_rresp  <= w_ar_oor ? 2'b10 : 2'b00;
    end else if (r_rvalid && s_axi.S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < int'(C_NUM_REGS); i++) reg_out[32*i +: 32] = r_regs[i];
  end

  assign reg_wr               = r_reg_wr;
  assign s_axi.S_AXI_AWREADY  = w_awready;
  assign s_axi.S_AXI_WREADY   = w_wready;
  assign s_axi.S_AXI_ARREADY  = w_arready;
  assign s_axi.S_AXI_BVALID   = r_bvalid;
  assign s_axi.S_AXI_BRESP    = r_bresp;
  assign s_axi.S_AXI_RVALID   = r_rvalid;
  assign s_axi.S_AXI_RDATA    = {{(C_S_AXI_DATA_WIDTH-32){1'b0}}, r_rdata};
  assign s_axi.S_AXI_RRESP    = r_rresp;

endmodule

// File: tb/tb_accel_axil_regs.sv
// Scoreboard bench for accel_axil_regs: expected B/R responses are queued at issue time
// and compared by a monitor when the handshake occurs.
module tb_accel_axil_regs;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] reg_out;
  logic [3:0]   reg_wr;

  always #5 clk = ~clk;

  accel_axil_regs_if #(.C_S_AXI_ADDR_WIDTH(6), .C_S_AXI_DATA_WIDTH(32)) axi ();

  accel_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .C_NUM_REGS(4)
  ) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .s_axi       (axi.slave),
    .reg_out     (reg_out),
    .reg_wr      (reg_wr)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [1:0]  exp_b_q  [$];
  logic [31:0] exp_rd_q [$];
  logic [1:0]  exp_rr_q [$];
  logic [31:0] mdl      [4];
  int          wr_cnt   [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit addr_oor(input logic [5:0] a);
`ifdef ACCEL_AXIL_SLVERR_EN
    return a[5:4] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_b_q.push_back(addr_oor(a) ? 2'b10 : 2'b00);
    if (!addr_oor(a)) begin
      for (int k = 0; k < 4; k++) if (s[k]) mdl[a[3:2]][8*k +: 8] = d[8*k +: 8];
    end
  endtask

  task automatic model_read(input logic [5:0] a);
    exp_rd_q.push_back(addr_oor(a) ? 32'h0 : mdl[a[3:2]]);
    exp_rr_q.push_back(addr_oor(a) ? 2'b10 : 2'b00);
  endtask

  // Response monitor: pops the scoreboard on every B/R handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (axi.S_AXI_BVALID && axi.S_AXI_BREADY) begin
        if (exp_b_q.size() == 0) check("b_unexpected", {31'b0, axi.S_AXI_BVALID}, 32'h0);
        else check("bresp", {30'b0, axi.S_AXI_BRESP}, {30'b0, exp_b_q.pop_front()});
      end
      if (axi.S_AXI_RVALID && axi.S_AXI_RREADY) begin
        if (exp_rd_q.size() == 0) check("r_unexpected", {31'b0, axi.S_AXI_RVALID}, 32'h0);
        else begin
          check("rdata", axi.S_AXI_RDATA, exp_rd_q.pop_front());
          check("rresp", {30'b0, axi.S_AXI_RRESP}, {30'b0, exp_rr_q.pop_front()});
        end
      end
      for (int i = 0; i < 4; i++) if (reg_wr[i]) wr_cnt[i]++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    logic aw_f, w_f;
    model_write(a, d, s);
    axi.S_AXI_AWADDR  = a;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WDATA   = d;
    axi.S_AXI_WSTRB   = s;
    axi.S_AXI_WVALID  = 1'b1;
    for (int c = 0; c < 20 && (axi.S_AXI_AWVALID || axi.S_AXI_WVALID); c++) begin
      @(negedge clk);
      aw_f = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      w_f  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      @(posedge clk);
      #1;
      if (aw_f) axi.S_AXI_AWVALID = 1'b0;
      if (w_f)  axi.S_AXI_WVALID  = 1'b0;
    end
    if (axi.S_AXI_AWVALID || axi.S_AXI_WVALID) begin
      check("wr_hs_timeout", {31'b0, axi.S_AXI_AWVALID | axi.S_AXI_WVALID}, 32'h0);
      axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_WVALID  = 1'b0;
    end
  endtask

  task automatic issue_rd(input logic [5:0] a);
    logic ar_f;
    model_read(a);
    axi.S_AXI_ARADDR  = a;
    axi.S_AXI_ARVALID = 1'b1;
    for (int c = 0; c < 20 && axi.S_AXI_ARVALID; c++) begin
      @(negedge clk);
      ar_f = axi.S_AXI_ARREADY;
      @(posedge clk);
      #1;
      if (ar_f) axi.S_AXI_ARVALID = 1'b0;
    end
    if (axi.S_AXI_ARVALID) begin
      check("rd_hs_timeout", {31'b0, axi.S_AXI_ARVALID}, 32'h0);
      axi.S_AXI_ARVALID = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 50 && (exp_b_q.size() != 0 || exp_rd_q.size() != 0); c++) cycles(1);
    if (exp_b_q.size() != 0 || exp_rd_q.size() != 0) begin
      check("drain_timeout", exp_b_q.size() + exp_rd_q.size(), 32'h0);
      exp_b_q.delete();
      exp_rd_q.delete();
      exp_rr_q.delete();
    end
    cycles(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] vals [4];
    int c0;
    vals[0] = 32'h0101FFFF; vals[1] = 32'hABCD0001;
    vals[2] = 32'hDEAD0011; vals[3] = 32'hBEEF0011;
    for (int i = 0; i < 4; i++) begin mdl[i] = '0; wr_cnt[i] = 0; end
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA = '0; axi.S_AXI_WSTRB = '0; axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_BREADY = 1'b1;
    axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", {31'b0, axi.S_AXI_AWREADY}, 32'h0);
    check("rst_wready", {31'b0, axi.S_AXI_WREADY}, 32'h0);
    check("rst_arready", {31'b0, axi.S_AXI_ARREADY}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {29'b0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY},
          32'h7);
    check("post_rst_valid", {30'b0, axi.S_AXI_BVALID, axi.S_AXI_RVALID}, 32'h0);
    check("post_rst_rdata", axi.S_AXI_RDATA, 32'h0);
    check("post_rst_reg_out", {31'b0, reg_out != '0}, 32'h0);
    check("post_rst_reg_wr", {28'b0, reg_wr}, 32'h0);
    @(posedge clk); #1;

    // Write then read back each register
    for (int i = 0; i < 4; i++) begin
      issue_wr(6'(4 * i), vals[i], 4'hF);
      wait_drain();
      issue_rd(6'(4 * i));
      wait_drain();
      check("reg_wr_count", wr_cnt[i], 32'd1);
    end

    // W three cycles ahead of AW
    c0 = wr_cnt[1];
    model_write(6'h04, 32'h12345678, 4'hF);
    axi.S_AXI_WDATA = 32'h12345678; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
    @(negedge clk); check("wfirst_wready", {31'b0, axi.S_AXI_WREADY}, 32'h1);
    @(posedge clk); #1 axi.S_AXI_WVALID = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("wready_low_held", {31'b0, axi.S_AXI_WREADY}, 32'h0);
      check("no_b_w_only", {31'b0, axi.S_AXI_BVALID}, 32'h0);
      @(posedge clk); #1;
    end
    axi.S_AXI_AWADDR = 6'h04; axi.S_AXI_AWVALID = 1'b1;
    @(negedge clk); check("wfirst_awready", {31'b0, axi.S_AXI_AWREADY}, 32'h1);
    @(posedge clk); #1 axi.S_AXI_AWVALID = 1'b0;
    @(negedge clk); check("no_commit_at_aw", {31'b0, axi.S_AXI_BVALID}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bvalid_after_commit", {31'b0, axi.S_AXI_BVALID}, 32'h1);
    check("reg1_committed", reg_out[63:32], 32'h12345678);
    check("reg_wr_not_yet", {28'b0, reg_wr}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk); check("reg_wr1_pulse", {28'b0, reg_wr}, 32'h2);
    @(posedge clk); #1;
    wait_drain();
    check("reg_wr1_once", wr_cnt[1], c0 + 1);

    // Byte strobe
    issue_wr(6'h08, 32'h000000AA, 4'h1);
    wait_drain();
    issue_rd(6'h08);
    wait_drain();
    check("strb_reg2", reg_out[95:64], 32'hDEAD00AA);

    // Back-pressure on B and R
    axi.S_AXI_BREADY = 1'b0; axi.S_AXI_RREADY = 1'b0;
    issue_wr(6'h00, 32'hCAFEF00D, 4'hF);
    issue_rd(6'h04);
    cycles(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valids", {30'b0, axi.S_AXI_BVALID, axi.S_AXI_RVALID}, 32'h3);
      check("bp_rdata", axi.S_AXI_RDATA, 32'h12345678);
      check("bp_readys", {29'b0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY},
            32'h0);
      @(posedge clk); #1;
    end
    axi.S_AXI_BREADY = 1'b1; axi.S_AXI_RREADY = 1'b1;
    wait_drain();
    @(negedge clk);
    check("bp_readys_back", {29'b0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY},
          32'h7);
    @(posedge clk); #1;

    // Read on the same edge as a commit to the same register
    axi.S_AXI_AWADDR = 6'h0C; axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WDATA = 32'h55; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    check("same_edge_aw_w_ready", {30'b0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 32'h3);
    @(posedge clk); #1;
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
    model_read(6'h0C);
    model_write(6'h0C, 32'h55, 4'hF);
    axi.S_AXI_ARADDR = 6'h0C; axi.S_AXI_ARVALID = 1'b1;
    @(negedge clk); check("same_edge_arready", {31'b0, axi.S_AXI_ARREADY}, 32'h1);
    @(posedge clk); #1 axi.S_AXI_ARVALID = 1'b0;
    wait_drain();
    issue_rd(6'h0C);
    wait_drain();

    // Reset with AW held and a read response pending
    axi.S_AXI_RREADY = 1'b0;
    issue_rd(6'h00);
    axi.S_AXI_AWADDR = 6'h00; axi.S_AXI_AWVALID = 1'b1;
    @(negedge clk); check("mid_awready", {31'b0, axi.S_AXI_AWREADY}, 32'h1);
    @(posedge clk); #1 axi.S_AXI_AWVALID = 1'b0;
    @(negedge clk); check("mid_rvalid", {31'b0, axi.S_AXI_RVALID}, 32'h1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_valids", {30'b0, axi.S_AXI_BVALID, axi.S_AXI_RVALID}, 32'h0);
    exp_b_q.delete(); exp_rd_q.delete(); exp_rr_q.delete();
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    @(posedge clk); #1 rst = 1'b0;
    axi.S_AXI_RREADY = 1'b1;
    axi.S_AXI_WDATA = 32'h77777777; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
    @(negedge clk); check("mid_wready", {31'b0, axi.S_AXI_WREADY}, 32'h1);
    @(posedge clk); #1 axi.S_AXI_WVALID = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_b_after_rst", {31'b0, axi.S_AXI_BVALID}, 32'h0);
      @(posedge clk); #1;
    end
    check("rst_regs_zero", {31'b0, reg_out != '0}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      issue_rd(6'(4 * i));
      wait_drain();
    end
    model_write(6'h04, 32'h77777777, 4'hF);
    axi.S_AXI_AWADDR = 6'h04; axi.S_AXI_AWVALID = 1'b1;
    @(negedge clk); check("post_rst_awready", {31'b0, axi.S_AXI_AWREADY}, 32'h1);
    @(posedge clk); #1 axi.S_AXI_AWVALID = 1'b0;
    wait_drain();
    check("post_rst_reg1", reg_out[63:32], 32'h77777777);

    // Out-of-window address
    c0 = wr_cnt[0];
    issue_wr(6'h20, 32'h5A5A5A5A, 4'hF);
    wait_drain();
    issue_rd(6'h20);
    wait_drain();
    issue_rd(6'h00);
    wait_drain();
`ifdef ACCEL_AXIL_SLVERR_EN
    check("oor_reg_wr", wr_cnt[0], c0);
`else
    check("alias_reg_wr", wr_cnt[0], c0 + 1);
`endif
    for (int i = 0; i < 4; i++) check("final_reg_out", reg_out[32*i +: 32], mdl[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/accel_axil_regs.md
# accel_axil_regs

AXI4-Lite slave register file that is the responder end of the accelerator's S00_AXI control port. It accepts single-beat writes and reads from the AXI4-Lite master, holds C_NUM_REGS 32-bit registers, honours byte strobes, and returns OKAY responses. It exports every register value and a per-register write pulse to the accelerator core.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte address width.
- C_NUM_REGS, 4, number of registers; power of two, at most 2^(C_S_AXI_ADDR_WIDTH-2).
- S_AXI_ACLK  in  1  single clock; all logic is on the rising edge.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- reg_out  out  32*C_NUM_REGS  register contents; register i is at bits [32*i+31:32*i].
- reg_wr  out  C_NUM_REGS  one-cycle pulse in the cycle after register i is committed.

## Operation
- Register index is addr[log2(C_NUM_REGS)+1:2]. addr[1:0] is ignored.
- Write path: AW and W are captured independently, in either order, into holding registers aw_held and w_held.
  - AWREADY = !aw_held && !BVALID && !reset.
  - WREADY = !w_held && !BVALID && !reset.
- Commit happens on the first edge where both aw_held and w_held are set:
  - byte k of the target register is updated only where WSTRB[k]=1;
  - BVALID is set and BRESP = 00;
  - both held flags are cleared;
  - reg_wr[index] pulses on the next cycle.
- BVALID holds until a BREADY handshake. No new AW or W is accepted while BVALID=1.
- Read path: ARREADY = !RVALID && !reset.
  - On the AR handshake edge, RDATA is loaded with reg[index], RVALID is set and RRESP = 00.
  - RVALID and RDATA hold stable until an RREADY handshake.
- Reads and writes are fully independent.
  - If a commit and an AR handshake fall on the same edge for the same register, RDATA returns the pre-write value.
- Reset (any cycle, mid-transaction included) clears:
  - all registers, aw_held, w_held, BVALID, RVALID and reg_wr to 0;
  - RDATA, BRESP and RRESP to 0.
  - In-flight transactions are discarded; no response is issued for them.

## Timing
- Reset values: all READY outputs 0 while S_AXI_ARESET=1, and AWREADY/WREADY/ARREADY become 1 on the first cycle after release. All VALID outputs are 0, RDATA=0, reg_out=0, reg_wr=0.
- Write latency: AW and W handshake on edge N, commit on edge N+1, BVALID=1 after N+1, reg_wr pulse after N+2.
- If AW arrives k cycles before W, commit is on the edge after the W handshake.
- Maximum write throughput is one write per 3 cycles when BREADY is held high.
- Read latency: AR handshake on edge N, RVALID=1 after N. Maximum read throughput is one read per 2 cycles when RREADY is held high.
- VALID outputs never drop without a handshake, except on reset.

## Configuration
- ACCEL_AXIL_SLVERR_EN defined:
  - addresses at or above 4*C_NUM_REGS are out of range;
  - an out-of-range write commits nothing, gives BRESP=10 (SLVERR) and no reg_wr pulse;
  - an out-of-range read returns RDATA=0 and RRESP=10.
- ACCEL_AXIL_SLVERR_EN undefined: upper address bits are ignored, so addresses alias modulo 4*C_NUM_REGS and every response is OKAY.

## Test plan
- Write then read back 0x0101FFFF, 0xABCD0001, 0xDEAD0011 and 0xBEEF0011 to 0x0, 0x4, 0x8 and 0xC -> each read returns the written value, and every BRESP and RRESP is 00.
- W issued 3 cycles before AW to 0x4 with data 0x12345678 -> WREADY drops after the W handshake, commit happens the edge after AW, and reg_wr[1] pulses exactly once.
- Register 0x8 holds 0xDEAD0011; write 0x000000AA with WSTRB=0001 -> readback is 0xDEAD00AA.
- Hold BREADY and RREADY low for 5 cycles -> BVALID, RVALID and RDATA stay stable, and AWREADY, WREADY and ARREADY stay 0 until the respective handshake.
- Read of 0xC on the same edge as a commit of 0x55 to 0xC (old value 0xBEEF0011) -> RDATA is 0xBEEF0011, and a subsequent read returns 0x00000055.
- Assert reset while aw_held=1 and RVALID=1 -> no BVALID, RVALID drops, all registers read 0.
- Write to 0x20 -> with ACCEL_AXIL_SLVERR_EN, BRESP=10 and no register changes; without it, BRESP=00 and register 0 is updated.
